systolic_array_rxc: RTL and testbench
=====================================

// Module: systolic_array_rxc
//
// PURPOSE
// - Parametrised output-stationary systolic matrix-multiply array, ROWS x COLS MAC PEs. Successor to fixed 4x4 tiles.
// - Computes C[ROWS][COLS] = A[ROWS][K] * B[K][COLS], where K is given per job.
// - Includes input skew, a job FSM, stall-on-bubble, and a backpressured result drain.
// - East/south pass-through edges let arrays cascade into larger meshes.
//
// PARAMETERS
// - ROWS    4   PE rows; A-operand lanes (min 1)
// - COLS    4   PE columns; B-operand lanes (min 1)
// - DATA_W  32  operand width, two's complement
// - ACC_W   48  accumulator width, two's complement, wraps modulo 2^ACC_W
// - K_W     16  width of the K_LEN job-length field
//
// PORTS
// - CLK        in   1               clock, rising edge
// - RST        in   1               synchronous active-high reset
// - EN         in   1               global clock enable; 0 freezes all state
// - START      in   1               job request; sampled in IDLE only
// - K_LEN      in   K_W             inner dimension K; sampled with START
// - BUSY       out  1               high in any state except IDLE
// - DONE       out  1               one-cycle pulse after the last drain beat
// - IN_VALID   in   1               A/B operand column valid
// - IN_READY   out  1               high in LOAD only
// - N_RX       in   DATA_W x ROWS   A[i][k], west edge, unskewed
// - N_CX       in   DATA_W x COLS   B[k][j], north edge, unskewed
// - N_RY       out  DATA_W x ROWS   east pass-through of the A stream
// - N_CY       out  DATA_W x COLS   south pass-through of the B stream
// - OUT_ROW    out  ACC_W x COLS    one row of C per drain beat
// - OUT_VALID  out  1               OUT_ROW valid
// - OUT_READY  in   1               drain backpressure
//
// BEHAVIOUR
// - Priority: RST > EN. RST clears the FSM, all counters, skew registers and accumulators, even with EN=0.
//   - After reset: IN_READY, BUSY, DONE and OUT_VALID are 0; N_RY, N_CY and OUT_ROW are 0.
// - With EN=0 and RST=0, nothing changes.
// - All rules below apply only to cycles with EN=1.
// - FSM states: IDLE, LOAD, FLUSH, DRAIN.
//   - IDLE: on START, latch K_LEN and clear all accumulators. Next state is LOAD if K_LEN>0, else DRAIN (C is all zeros).
//   - LOAD: the array steps only on IN_VALID & IN_READY; a cycle with IN_VALID=0 is a full-array stall. After K accepted beats, go to FLUSH.
//   - FLUSH: steps every cycle, injecting zeros on both edges. Lasts exactly ROWS+COLS-2 cycles, then DRAIN (0 cycles when ROWS=COLS=1).
//   - DRAIN: ROWS beats, row 0 first.
//     - A beat completes on OUT_VALID & OUT_READY.
//     - OUT_ROW and OUT_VALID hold stable while OUT_READY=0.
//     - After the last beat: DONE=1 for one cycle and go to IDLE.
// - START outside IDLE is ignored. K_LEN is only sampled in IDLE.
// - Skew: lane i of N_RX is delayed i steps; lane j of N_CX is delayed j steps. Skew registers advance only on array steps.
// - Timing: PE(i,j) performs the MAC for a[i][k]*b[k][j] on step k+i+j.
//   - Step 0 is the first accepted beat.
//   - The last MAC is on step K+ROWS+COLS-3.
// - PE datapath:
//   - The product is DATA_W x DATA_W -> 2*DATA_W, signed.
//   - It is sign-extended, or truncated to its low ACC_W bits, then added with wrap.
//   - The PE registers the A value eastward and the B value southward on each step.
// - N_RY[i] / N_CY[j] are the registered outputs of the east-most / south-most PE. They update only on steps.
// - Latency from START to first OUT_VALID, with no stalls: 1 + K + ROWS+COLS-2 cycles.
// - RST mid-job aborts with no DONE pulse. Results are lost.
//
// STRUCTURE
// - Shared package sa_pkg:
//   - state_t enum {IDLE, LOAD, FLUSH, DRAIN}
//   - function flush_len(ROWS,COLS)
//   - common DATA_W / ACC_W defaults
// - Sub-module sa_pe:
//   - one PE with CLK, RST, STEP, CLR, A/B in, A/B out, ACC out
//   - instantiated ROWS x COLS in a generate loop
// - Top level holds the FSM, the K and flush counters, the skew shift registers, and the drain row mux with its row counter.
//
// TESTING (ROWS=COLS=4 unless stated)
// - Identity: A=I4, B rows {1..4},{5..8},{9..12},{13..16}, K=4, IN_VALID held high, OUT_READY=1.
//   - OUT_ROW beats equal the B rows in order.
//   - First OUT_VALID comes 11 cycles after START.
//   - DONE pulses 1 cycle after beat 4.
// - Bubbles: same job with IN_VALID toggled 1,0,1,0...
//   - Identical results.
//   - First OUT_VALID delayed by exactly the number of IN_VALID=0 cycles in LOAD.
// - Signed/wrap: DATA_W=32, ACC_W=48, A=all 0x7FFFFFFF, B=all 0x7FFFFFFF, K=4.
//   - Every element equals (4*(2^31-1)^2) mod 2^48, as signed.
//   - Also A=-1, B=3 gives -12 everywhere.
// - Drain backpressure: OUT_READY pattern 0,0,1,0,1,1,0,1.
//   - OUT_ROW stays stable while stalled.
//   - Exactly 4 beats, no duplicates.
//   - DONE follows the 4th handshake.
// - Control edges:
//   - K_LEN=0: 4 zero rows, then DONE.
//   - START during LOAD: ignored.
//   - EN=0 for 5 cycles mid-FLUSH: results unchanged, latency +5.
// - Reset mid-job: assert RST in cycle 3 of DRAIN.
//   - Next cycle all outputs are 0 and BUSY=0, with no DONE.
//   - A fresh START then produces correct results.
//   - Run on ROWS=2, COLS=3 and on ROWS=COLS=1.

Source files
------------

// File: rtl/sa_pkg.sv
// Shared types and defaults for the systolic matrix-multiply array.
//   state_t   : job FSM states
//   flush_len : zero-injection steps needed to drain the skewed wavefront
package sa_pkg;

  localparam int unsigned DATA_W_DEF = 32;
  localparam int unsigned ACC_W_DEF  = 48;
  localparam int unsigned K_W_DEF    = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    FLUSH = 2'd2,
    DRAIN = 2'd3
  } state_t;

  // Steps after the last operand beat until PE(ROWS-1,COLS-1) has seen it.
  function automatic int unsigned flush_len(input int unsigned rows, input int unsigned cols);
    return rows + cols - 2;
  endfunction

endpackage

// File: rtl/sa_pe.sv
// One output-stationary MAC processing element.
//   CLK, RST      : clock, synchronous active-high reset
//   STEP          : advance the array (MAC + forward operands)
//   CLR           : clear the accumulator for a new job
//   A_IN / B_IN   : operands from west / north neighbour
//   A_OUT / B_OUT : registered operands towards east / south neighbour
//   ACC           : registered accumulator
//   ACC_NXT_C     : combinational next accumulator value
module sa_pe
  import sa_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned ACC_W  = ACC_W_DEF
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              STEP,
  input  logic              CLR,
  input  logic [DATA_W-1:0] A_IN,
  input  logic [DATA_W-1:0] B_IN,
  output logic [DATA_W-1:0] A_OUT,
  output logic [DATA_W-1:0] B_OUT,
  output logic [ACC_W-1:0]  ACC,
  output logic [ACC_W-1:0]  ACC_NXT_C
);

  localparam int unsigned PROD_W = 2 * DATA_W;

  logic signed [PROD_W-1:0] w_prod;
  logic        [ACC_W-1:0]  w_prod_acc;
  logic        [DATA_W-1:0] r_a;
  logic        [DATA_W-1:0] r_b;
  logic        [ACC_W-1:0]  r_acc;

  // Full-precision signed product; the size cast sign-extends or truncates to ACC_W.
  assign w_prod     = PROD_W'($signed(A_IN)) * PROD_W'($signed(B_IN));
  assign w_prod_acc = ACC_W'(w_prod);

  always_comb begin
    ACC_NXT_C = r_acc;
    if (CLR) begin
      ACC_NXT_C = '0;
    end else if (STEP) begin
      ACC_NXT_C = r_acc + w_prod_acc;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_a   <= '0;
      r_b   <= '0;
      r_acc <= '0;
    end else begin
      r_acc <= ACC_NXT_C;
      if (STEP) begin
        r_a <= A_IN;
        r_b <= B_IN;
      end
    end
  end

  assign A_OUT = r_a;
  assign B_OUT = r_b;
  assign ACC   = r_acc;

endmodule

// File: rtl/systolic_array_rxc.sv
// ROWS x COLS output-stationary systolic matrix multiplier C = A * B.
//   CLK, RST, EN          : clock, sync active-high reset, global enable
//   START, K_LEN          : job request and inner dimension (IDLE only)
//   BUSY, DONE            : job in progress, end-of-job pulse
//   IN_VALID/IN_READY     : operand column handshake (A on N_RX, B on N_CX)
//   N_RY, N_CY            : east/south pass-through of the operand streams
//   OUT_ROW/OUT_VALID/OUT_READY : one C row per drain beat, row 0 first
module systolic_array_rxc
  import sa_pkg::*;
#(
  parameter int unsigned ROWS   = 4,
  parameter int unsigned COLS   = 4,
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned ACC_W  = ACC_W_DEF,
  parameter int unsigned K_W    = K_W_DEF
) (
  input  logic                         CLK,
  input  logic                         RST,
  input  logic                         EN,
  input  logic                         START,
  input  logic [K_W-1:0]               K_LEN,
  output logic                         BUSY,
  output logic                         DONE,
  input  logic                         IN_VALID,
  output logic                         IN_READY,
  input  logic [ROWS-1:0][DATA_W-1:0]  N_RX,
  input  logic [COLS-1:0][DATA_W-1:0]  N_CX,
  output logic [ROWS-1:0][DATA_W-1:0]  N_RY,
  output logic [COLS-1:0][DATA_W-1:0]  N_CY,
  output logic [COLS-1:0][ACC_W-1:0]   OUT_ROW,
  output logic                         OUT_VALID,
  input  logic                         OUT_READY
);

  localparam int unsigned FLUSH_LEN = flush_len(ROWS, COLS);
  localparam int unsigned FL_LAST   = (FLUSH_LEN > 0) ? FLUSH_LEN - 1 : 0;
  localparam int unsigned FL_W      = (FLUSH_LEN > 1) ? $clog2(FLUSH_LEN) : 1;
  localparam int unsigned ROW_W     = (ROWS > 1) ? $clog2(ROWS) : 1;

  state_t                     r_state;
  state_t                     w_state_nxt;
  logic [K_W-1:0]             r_k_len;
  logic [K_W-1:0]             r_k_cnt;
  logic [FL_W-1:0]            r_fl_cnt;
  logic [ROW_W-1:0]           r_row_cnt;
  logic                       r_busy;
  logic                       r_in_ready;
  logic                       r_done;
  logic                       r_out_valid;
  logic [COLS-1:0][ACC_W-1:0] r_out_row;

  logic                       w_step;
  logic                       w_clr;
  logic                       w_beat;
  logic                       w_last;
  logic                       w_enter_drain;
  logic                       w_pe_step;
  logic                       w_pe_clr;
  logic [ROW_W-1:0]           w_row_sel;
  logic [COLS-1:0][ACC_W-1:0] w_row_data;

  logic [DATA_W-1:0] w_a       [ROWS][COLS+1];
  logic [DATA_W-1:0] w_b       [ROWS+1][COLS];
  logic [ACC_W-1:0]  w_acc     [ROWS][COLS];
  logic [ACC_W-1:0]  w_acc_nxt [ROWS][COLS];

  // Next-state and control decode.
  always_comb begin
    w_state_nxt = r_state;
    w_step      = 1'b0;
    w_clr       = 1'b0;
    w_beat      = 1'b0;
    w_last      = (r_row_cnt == ROW_W'(ROWS - 1));
    case (r_state)
      IDLE: begin
        if (START) begin
          w_clr       = 1'b1;
          w_state_nxt = (K_LEN != '0) ? LOAD : DRAIN;
        end
      end
      LOAD: begin
        if (IN_VALID) begin
          w_step = 1'b1;
          if (r_k_cnt == r_k_len - K_W'(1)) begin
            w_state_nxt = (FLUSH_LEN == 0) ? DRAIN : FLUSH;
          end
        end
      end
      FLUSH: begin
        w_step = 1'b1;
        if (r_fl_cnt == FL_W'(FL_LAST)) begin
          w_state_nxt = DRAIN;
        end
      end
      DRAIN: begin
        if (r_out_valid && OUT_READY) begin
          w_beat = 1'b1;
          if (w_last) begin
            w_state_nxt = IDLE;
          end
        end
      end
      default: w_state_nxt = IDLE;
    endcase
    w_enter_drain = (w_state_nxt == DRAIN) && (r_state != DRAIN);
  end

  assign w_pe_step = EN & w_step;
  assign w_pe_clr  = EN & w_clr;

  // Row to present next: row 0 on drain entry (from next-acc, since the
  // final MAC lands on that same edge), otherwise the following row.
  always_comb begin
    w_row_sel  = w_enter_drain ? '0 : r_row_cnt + ROW_W'(1);
    w_row_data = '0;
    for (int r = 0; r < int'(ROWS); r++) begin
      if (ROW_W'(r) == w_row_sel) begin
        for (int c = 0; c < int'(COLS); c++) begin
          w_row_data[c] = w_enter_drain ? w_acc_nxt[r][c] : w_acc[r][c];
        end
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state     <= IDLE;
      r_k_len     <= '0;
      r_k_cnt     <= '0;
      r_fl_cnt    <= '0;
      r_row_cnt   <= '0;
      r_busy      <= 1'b0;
      r_in_ready  <= 1'b0;
      r_done      <= 1'b0;
      r_out_valid <= 1'b0;
      r_out_row   <= '0;
    end else if (EN) begin
      r_state    <= w_state_nxt;
      r_busy     <= (w_state_nxt != IDLE);
      r_in_ready <= (w_state_nxt == LOAD);
      r_done     <= w_beat & w_last;
      if (w_clr) begin
        r_k_len <= K_LEN;
        r_k_cnt <= '0;
      end else if (w_step && (r_state == LOAD)) begin
        r_k_cnt <= r_k_cnt + K_W'(1);
      end
      if (r_state == FLUSH) begin
        r_fl_cnt <= r_fl_cnt + FL_W'(1);
      end else begin
        r_fl_cnt <= '0;
      end
      if (w_enter_drain) begin
        r_row_cnt   <= '0;
        r_out_valid <= 1'b1;
        r_out_row   <= w_row_data;
      end else if (w_beat) begin
        if (w_last) begin
          r_out_valid <= 1'b0;
        end else begin
          r_row_cnt <= r_row_cnt + ROW_W'(1);
          r_out_row <= w_row_data;
        end
      end
    end
  end

  // West-edge skew: lane i delayed i steps; zeros enter outside LOAD.
  for (genvar i = 0; i < int'(ROWS); i++) begin : g_skew_a
    logic [DATA_W-1:0] w_in;
    assign w_in = (r_state == LOAD) ? N_RX[i] : '0;
    if (i == 0) begin : g_direct
      assign w_a[i][0] = w_in;
    end else begin : g_dly
      logic [DATA_W-1:0] r_sh [i];
      always_ff @(posedge CLK) begin
        if (RST) begin
          for (int d = 0; d < i; d++) r_sh[d] <= '0;
        end else if (w_pe_step) begin
          r_sh[0] <= w_in;
          for (int d = 1; d < i; d++) r_sh[d] <= r_sh[d-1];
        end
      end
      assign w_a[i][0] = r_sh[i-1];
    end
  end

  // North-edge skew: lane j delayed j steps.
  for (genvar j = 0; j < int'(COLS); j++) begin : g_skew_b
    logic [DATA_W-1:0] w_in;
    assign w_in = (r_state == LOAD) ? N_CX[j] : '0;
    if (j == 0) begin : g_direct
      assign w_b[0][j] = w_in;
    end else begin : g_dly
      logic [DATA_W-1:0] r_sh [j];
      always_ff @(posedge CLK) begin
        if (RST) begin
          for (int d = 0; d < j; d++) r_sh[d] <= '0;
        end else if (w_pe_step) begin
          r_sh[0] <= w_in;
          for (int d = 1; d < j; d++) r_sh[d] <= r_sh[d-1];
        end
      end
      assign w_b[0][j] = r_sh[j-1];
    end
  end

  for (genvar i = 0; i < int'(ROWS); i++) begin : g_row
    for (genvar j = 0; j < int'(COLS); j++) begin : g_col
      sa_pe #(
        .DATA_W (DATA_W),
        .ACC_W  (ACC_W)
      ) u_pe (
        .CLK       (CLK),
        .RST       (RST),
        .STEP      (w_pe_step),
        .CLR       (w_pe_clr),
        .A_IN      (w_a[i][j]),
        .B_IN      (w_b[i][j]),
        .A_OUT     (w_a[i][j+1]),
        .B_OUT     (w_b[i+1][j]),
        .ACC       (w_acc[i][j]),
        .ACC_NXT_C (w_acc_nxt[i][j])
      );
    end
    assign N_RY[i] = w_a[i][COLS];
  end

  for (genvar j = 0; j < int'(COLS); j++) begin : g_south
    assign N_CY[j] = w_b[ROWS][j];
  end

  assign BUSY      = r_busy;
  assign DONE      = r_done;
  assign IN_READY  = r_in_ready;
  assign OUT_VALID = r_out_valid;
  assign OUT_ROW   = r_out_row;

endmodule

// File: tb/tb_systolic_array_rxc.sv
// Directed bench for systolic_array_rxc: 4x4 main instance plus 2x3 and 1x1
// instances for the mid-drain reset scenario.
module tb_systolic_array_rxc;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // 4x4 instance
  logic                rst, en, start, busy, done, in_valid, in_ready;
  logic                out_valid, out_ready;
  logic [15:0]         k_len;
  logic [3:0][31:0]    rx, cx, ry, cy;
  logic [3:0][47:0]    out_row;

  systolic_array_rxc #(.ROWS(4), .COLS(4)) u_dut44 (
    .CLK(clk), .RST(rst), .EN(en), .START(start), .K_LEN(k_len),
    .BUSY(busy), .DONE(done), .IN_VALID(in_valid), .IN_READY(in_ready),
    .N_RX(rx), .N_CX(cx), .N_RY(ry), .N_CY(cy),
    .OUT_ROW(out_row), .OUT_VALID(out_valid), .OUT_READY(out_ready)
  );

  // 2x3 instance
  logic                s2_rst, s2_start, s2_busy, s2_done, s2_in_valid, s2_in_ready;
  logic                s2_out_valid, s2_out_ready;
  logic [15:0]         s2_k;
  logic [1:0][31:0]    s2_rx, s2_ry;
  logic [2:0][31:0]    s2_cx, s2_cy;
  logic [2:0][47:0]    s2_out_row;

  systolic_array_rxc #(.ROWS(2), .COLS(3)) u_dut23 (
    .CLK(clk), .RST(s2_rst), .EN(1'b1), .START(s2_start), .K_LEN(s2_k),
    .BUSY(s2_busy), .DONE(s2_done), .IN_VALID(s2_in_valid), .IN_READY(s2_in_ready),
    .N_RX(s2_rx), .N_CX(s2_cx), .N_RY(s2_ry), .N_CY(s2_cy),
    .OUT_ROW(s2_out_row), .OUT_VALID(s2_out_valid), .OUT_READY(s2_out_ready)
  );

  // 1x1 instance
  logic                s1_rst, s1_start, s1_busy, s1_done, s1_in_valid, s1_in_ready;
  logic                s1_out_valid, s1_out_ready;
  logic [15:0]         s1_k;
  logic [0:0][31:0]    s1_rx, s1_cx, s1_ry, s1_cy;
  logic [0:0][47:0]    s1_out_row;

  systolic_array_rxc #(.ROWS(1), .COLS(1)) u_dut11 (
    .CLK(clk), .RST(s1_rst), .EN(1'b1), .START(s1_start), .K_LEN(s1_k),
    .BUSY(s1_busy), .DONE(s1_done), .IN_VALID(s1_in_valid), .IN_READY(s1_in_ready),
    .N_RX(s1_rx), .N_CX(s1_cx), .N_RY(s1_ry), .N_CY(s1_cy),
    .OUT_ROW(s1_out_row), .OUT_VALID(s1_out_valid), .OUT_READY(s1_out_ready)
  );

  logic [31:0] ma [4][4];   // A[i][k]
  logic [31:0] mb [4][4];   // B[k][j]
  logic [47:0] ec [4][4];   // expected C[i][j]
  bit          pat [8] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [191:0] obs, input logic [191:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [191:0] exp_row(input int r);
    return {ec[r][3], ec[r][2], ec[r][1], ec[r][0]};
  endfunction

  task automatic set_ident();
    for (int i = 0; i < 4; i++) begin
      for (int j = 0; j < 4; j++) begin
        ma[i][j] = (i == j) ? 32'd1 : 32'd0;
        mb[i][j] = 32'(4 * i + j + 1);
        ec[i][j] = 48'(4 * i + j + 1);
      end
    end
  endtask

  task automatic set_const(input logic [31:0] a, input logic [31:0] b, input logic [47:0] c);
    for (int i = 0; i < 4; i++) begin
      for (int j = 0; j < 4; j++) begin
        ma[i][j] = a;
        mb[i][j] = b;
        ec[i][j] = c;
      end
    end
  endtask

  // One 4x4 job: issue START, stream K columns, wait for drain, check every beat.
  task automatic job4(input int k, input bit bubbles, input bit en_gap, input bit bp,
                      input bit start_mid, input int exp_lat, input string tag);
    int cyc, beat, guard, pidx;
    bit tog, rdy;
    logic [191:0] held;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    start     = 1'b1;
    k_len     = 16'(k);
    step();
    cyc   = 1;
    start = 1'b0;
    k_len = 16'd7;
    if (k > 0) chk({tag, " in_ready"}, in_ready, 1'b1);
    beat = 0; tog = 1'b1; guard = 0;
    while (beat < k && guard < 64) begin
      in_valid = bubbles ? tog : 1'b1;
      for (int i = 0; i < 4; i++) begin
        rx[i] = in_valid ? ma[i][beat] : 32'hBAD0_BAD0;
        cx[i] = in_valid ? mb[beat][i] : 32'h0BAD_0BAD;
      end
      start = start_mid && (beat == 1);
      k_len = 16'd0;
      step();
      cyc++; guard++;
      if (in_valid) beat++;
      tog = !tog;
    end
    start    = 1'b0;
    in_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      rx[i] = 32'h5555_5555;
      cx[i] = 32'hAAAA_AAAA;
    end
    if (en_gap) begin
      step(); step();
      cyc += 2;
      en = 1'b0;
      repeat (5) step();
      cyc += 5;
      chk({tag, " frozen busy/valid"}, {busy, out_valid}, 2'b10);
      en = 1'b1;
    end
    guard = 0;
    while (!out_valid && guard < 100) begin
      step();
      cyc++; guard++;
    end
    chk({tag, " latency"}, 192'(cyc), 192'(exp_lat));
    if (k > 0) begin
      chk({tag, " n_ry"}, ry, {ma[3][k-1], 96'd0});
      chk({tag, " n_cy"}, cy, {mb[k-1][3], 96'd0});
    end
    beat = 0; pidx = 0; guard = 0;
    while (beat < 4 && guard < 100) begin
      rdy = bp ? pat[pidx % 8] : 1'b1;
      pidx++;
      out_ready = rdy;
      chk($sformatf("%s valid b%0d", tag, beat), out_valid, 1'b1);
      chk($sformatf("%s row b%0d", tag, beat), out_row, exp_row(beat));
      held = out_row;
      step();
      guard++;
      if (rdy) beat++;
      else chk($sformatf("%s stable b%0d", tag, beat), out_row, held);
      chk($sformatf("%s done b%0d", tag, beat), done, rdy && (beat == 4));
    end
    out_ready = 1'b0;
    step();
    chk({tag, " end valid/busy/done"}, {out_valid, busy, done}, 3'b000);
  endtask

  // 2x3 job, K=2; optionally reset in the third DRAIN cycle.
  task automatic job23(input bit rst_mid, input string tag);
    int cyc, guard;
    logic [31:0] a23 [2][2];
    logic [31:0] b23 [2][3];
    a23 = '{'{32'd1, 32'd2}, '{32'd3, 32'd4}};
    b23 = '{'{32'd5, 32'd6, 32'd7}, '{32'd8, 32'd9, 32'd10}};
    s2_out_ready = 1'b0;
    s2_start = 1'b1; s2_k = 16'd2;
    step();
    cyc = 1; s2_start = 1'b0;
    for (int b = 0; b < 2; b++) begin
      s2_in_valid = 1'b1;
      for (int i = 0; i < 2; i++) s2_rx[i] = a23[i][b];
      for (int j = 0; j < 3; j++) s2_cx[j] = b23[b][j];
      step();
      cyc++;
    end
    s2_in_valid = 1'b0;
    guard = 0;
    while (!s2_out_valid && guard < 50) begin
      step(); cyc++; guard++;
    end
    chk({tag, " latency"}, 192'(cyc), 192'd6);
    chk({tag, " n_ry"}, s2_ry, {32'd4, 32'd0});
    chk({tag, " n_cy"}, s2_cy, {32'd10, 64'd0});
    if (rst_mid) begin
      step(); step();
      s2_rst = 1'b1;
      step();
      s2_rst = 1'b0;
      chk({tag, " post-rst ctl"}, {s2_busy, s2_done, s2_out_valid, s2_in_ready}, 4'b0000);
      chk({tag, " post-rst data"}, {s2_out_row, s2_ry, s2_cy}, '0);
      step();
      chk({tag, " no done"}, {s2_done, s2_busy}, 2'b00);
    end else begin
      s2_out_ready = 1'b1;
      chk({tag, " row0"}, s2_out_row, {48'd27, 48'd24, 48'd21});
      step();
      chk({tag, " done0"}, s2_done, 1'b0);
      chk({tag, " row1"}, s2_out_row, {48'd61, 48'd54, 48'd47});
      step();
      chk({tag, " done1"}, {s2_done, s2_out_valid}, 2'b10);
      s2_out_ready = 1'b0;
    end
  endtask

  // 1x1 job, K=3: 2*5 + (-3)*6 + 4*(-7) = -36.
  task automatic job11(input bit rst_mid, input string tag);
    int cyc, guard;
    logic [31:0] av [3];
    logic [31:0] bv [3];
    av = '{32'd2, 32'hFFFF_FFFD, 32'd4};
    bv = '{32'd5, 32'd6, 32'hFFFF_FFF9};
    s1_out_ready = 1'b0;
    s1_start = 1'b1; s1_k = 16'd3;
    step();
    cyc = 1; s1_start = 1'b0;
    for (int b = 0; b < 3; b++) begin
      s1_in_valid = 1'b1;
      s1_rx[0] = av[b];
      s1_cx[0] = bv[b];
      step();
      cyc++;
    end
    s1_in_valid = 1'b0;
    guard = 0;
    while (!s1_out_valid && guard < 50) begin
      step(); cyc++; guard++;
    end
    chk({tag, " latency"}, 192'(cyc), 192'd4);
    chk({tag, " n_ry/n_cy"}, {s1_ry, s1_cy}, {32'd4, 32'hFFFF_FFF9});
    if (rst_mid) begin
      step(); step();
      s1_rst = 1'b1;
      step();
      s1_rst = 1'b0;
      chk({tag, " post-rst ctl"}, {s1_busy, s1_done, s1_out_valid, s1_in_ready}, 4'b0000);
      chk({tag, " post-rst data"}, {s1_out_row, s1_ry, s1_cy}, '0);
      step();
      chk({tag, " no done"}, {s1_done, s1_busy}, 2'b00);
    end else begin
      s1_out_ready = 1'b1;
      chk({tag, " row0"}, s1_out_row, 48'hFFFF_FFFF_FFDC);
      step();
      chk({tag, " done"}, {s1_done, s1_out_valid}, 2'b10);
      s1_out_ready = 1'b0;
    end
  endtask

  initial begin
    rst = 1'b1; en = 1'b1; start = 1'b0; k_len = '0; in_valid = 1'b0; out_ready = 1'b0;
    rx = '0; cx = '0;
    s2_rst = 1'b1; s2_start = 1'b0; s2_k = '0; s2_in_valid = 1'b0; s2_out_ready = 1'b0;
    s2_rx = '0; s2_cx = '0;
    s1_rst = 1'b1; s1_start = 1'b0; s1_k = '0; s1_in_valid = 1'b0; s1_out_ready = 1'b0;
    s1_rx = '0; s1_cx = '0;
    repeat (2) step();
    chk("rst44 ctl", {busy, done, in_ready, out_valid}, 4'b0000);
    chk("rst44 data", {out_row, ry, cy}, '0);
    chk("rst23 ctl", {s2_busy, s2_done, s2_in_ready, s2_out_valid}, 4'b0000);
    chk("rst11 ctl", {s1_busy, s1_done, s1_in_ready, s1_out_valid}, 4'b0000);
    rst = 1'b0; s2_rst = 1'b0; s1_rst = 1'b0;
    step();

    set_ident();
    job4(4, 1'b0, 1'b0, 1'b0, 1'b0, 11, "ident");
    job4(4, 1'b1, 1'b0, 1'b0, 1'b0, 14, "bubble");

    // 4*(2^31-1)^2 mod 2^48 = 2^48 - 2^34 + 4
    set_const(32'h7FFF_FFFF, 32'h7FFF_FFFF, 48'hFFFC_0000_0004);
    job4(4, 1'b0, 1'b0, 1'b0, 1'b0, 11, "wrap");
    set_const(32'hFFFF_FFFF, 32'd3, 48'hFFFF_FFFF_FFF4);
    job4(4, 1'b0, 1'b0, 1'b0, 1'b0, 11, "neg");

    // A = 2*I with A[0][3]=1: row0 = 2*B0 + B3, others 2*Bi.
    set_ident();
    for (int i = 0; i < 4; i++) ma[i][i] = 32'd2;
    ma[0][3] = 32'd1;
    ec[0] = '{48'd15, 48'd18, 48'd21, 48'd24};
    ec[1] = '{48'd10, 48'd12, 48'd14, 48'd16};
    ec[2] = '{48'd18, 48'd20, 48'd22, 48'd24};
    ec[3] = '{48'd26, 48'd28, 48'd30, 48'd32};
    job4(4, 1'b0, 1'b0, 1'b1, 1'b0, 11, "bp");

    set_const(32'd9, 32'd9, 48'd0);
    job4(0, 1'b0, 1'b0, 1'b0, 1'b0, 1, "k0");

    set_ident();
    job4(4, 1'b0, 1'b0, 1'b0, 1'b1, 11, "start_mid");
    job4(4, 1'b0, 1'b1, 1'b0, 1'b0, 16, "en_gap");

    job23(1'b1, "r2c3 abort");
    job23(1'b0, "r2c3 fresh");
    job11(1'b1, "r1c1 abort");
    job11(1'b0, "r1c1 fresh");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
